btn_debounce: RTL and testbench

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/btn_pkg.sv | 36 +++
 rtl/btn_debounce_ch.sv | 155 +++++++++++++++
 rtl/btn_debounce.sv | 53 +++++
 tb/tb_btn_debounce.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the button debouncer:
//   - btn_state_e   : per-channel press/repeat FSM state
//   - DEF_*         : default timing constants for a 50 MHz system clock
//   - cnt_width()   : counter width able to hold 0 .. max_count-1 (at least 1 bit)
//   - max_u()       : larger of two unsigned values
// -----------------------------------------------------------------------------
package btn_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,  // level 0
        StHeld   = 2'd1,  // level 1, waiting for the first auto-repeat
        StRepeat = 2'd2   // level 1, periodic auto-repeat
    } btn_state_e;

    localparam int unsigned DEF_N_BTN           = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;   // 20 ms @ 50 MHz
    localparam int unsigned DEF_REPEAT_DELAY    = 25000000;  // 500 ms @ 50 MHz
    localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;   // 100 ms @ 50 MHz
    localparam bit          DEF_REPEAT_EN       = 1'b1;

    function automatic int unsigned cnt_width(input int unsigned max_count);
        int unsigned w;
        w = 1;
        if (max_count > 1) begin
            w = $clog2(max_count);
        end
        return w;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// -----------------------------------------------------------------------------
// btn_debounce_ch
// One button channel: 2-flop synchronizer, debounce counter, and the
// IDLE/HELD/REPEAT FSM that generates press, auto-repeat and release pulses.
// All outputs are registered.
//
// Parameters (all timing values must be >= 1):
//   DEBOUNCE_CYCLES : consecutive differing cycles needed to accept a change
//   REPEAT_DELAY    : cycles from the press pulse to the first repeat pulse
//   REPEAT_PERIOD   : cycles between subsequent repeat pulses
//   REPEAT_EN       : 1 enables auto-repeat
// Ports:
//   CLK_50M     in  system clock, rising edge
//   RST_N       in  asynchronous active-low reset
//   btn_in      in  raw asynchronous button level, 1 = pressed
//   btn_level   out debounced level
//   btn_press   out one-cycle pulse on accepted press and on each repeat tick
//   btn_release out one-cycle pulse on accepted release
// -----------------------------------------------------------------------------
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter bit          REPEAT_EN       = DEF_REPEAT_EN
) (
    input  logic CLK_50M,
    input  logic RST_N,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int unsigned DB_W  = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned RPT_W = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic [DB_W-1:0]  dcnt_q, dcnt_d;
    logic [RPT_W-1:0] rcnt_q, rcnt_d;
    btn_state_e       state_q, state_d;

    logic             rise, fall;

    // ------------------------------------------------------------------
    // Debounce: count consecutive cycles where the synchronized input
    // disagrees with the accepted level; flip the level on the last one.
    // ------------------------------------------------------------------
    always_comb begin
        dcnt_d  = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (dcnt_q == DB_LAST) begin
                level_d = ~level_q;
            end else if (dcnt_q != '1) begin
                dcnt_d = dcnt_q + DB_W'(1);
            end else begin
                dcnt_d = dcnt_q;
            end
        end
    end

    // Edges of the accepted level, visible in the same cycle the new level
    // is registered, so pulses line up with the first cycle of the new level.
    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    // ------------------------------------------------------------------
    // Press / repeat / release FSM. Release has priority over any repeat
    // tick falling in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StHeld;
                    rcnt_d  = '0;
                    press_d = 1'b1;
                end
            end

            StHeld: begin
                if (fall) begin
                    state_d   = StIdle;
                    rcnt_d    = '0;
                    release_d = 1'b1;
                end else if (REPEAT_EN && (rcnt_q == DELAY_LAST)) begin
                    state_d = StRepeat;
                    rcnt_d  = '0;
                    press_d = 1'b1;
                end else if (rcnt_q != '1) begin
                    rcnt_d = rcnt_q + RPT_W'(1);
                end
            end

            StRepeat: begin
                if (fall) begin
                    state_d   = StIdle;
                    rcnt_d    = '0;
                    release_d = 1'b1;
                end else if (rcnt_q == PERIOD_LAST) begin
                    rcnt_d  = '0;
                    press_d = 1'b1;
                end else if (rcnt_q != '1) begin
                    rcnt_d = rcnt_q + RPT_W'(1);
                end
            end

            default: begin
                state_d = StIdle;
                rcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            dcnt_q    <= '0;
            rcnt_q    <= '0;
            state_q   <= StIdle;
        end else begin
            sync1_q   <= btn_in;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            dcnt_q    <= dcnt_d;
            rcnt_q    <= rcnt_d;
            state_q   <= state_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// N_BTN independent debounced button channels with press, auto-repeat and
// release pulses. Each channel is a btn_debounce_ch instance.
//
// Parameters:
//   N_BTN           : number of channels
//   DEBOUNCE_CYCLES : stable cycles to accept a level change
//   REPEAT_DELAY    : cycles from press pulse to first repeat pulse
//   REPEAT_PERIOD   : cycles between subsequent repeat pulses
//   REPEAT_EN       : 1 enables auto-repeat
// Ports:
//   CLK_50M     in  [1]      system clock, rising edge
//   RST_N       in  [1]      asynchronous active-low reset
//   btn_in      in  [N_BTN]  raw button levels, 1 = pressed
//   btn_level   out [N_BTN]  debounced levels
//   btn_press   out [N_BTN]  press / repeat pulses
//   btn_release out [N_BTN]  release pulses
// -----------------------------------------------------------------------------
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN           = DEF_N_BTN,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter bit          REPEAT_EN       = DEF_REPEAT_EN
) (
    input  logic             CLK_50M,
    input  logic             RST_N,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (REPEAT_EN)
        ) u_ch (
            .CLK_50M     (CLK_50M),
            .RST_N       (RST_N),
            .btn_in      (btn_in[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce
// Two DUTs share inputs: u_dut_rep (auto-repeat on) and u_dut_norep (off).
// A reference model predicts pulses from a sliding window over the raw input
// history plus elapsed-time arithmetic for repeats; predicted pulse events
// are queued and a monitor pops/compares whenever a DUT emits a pulse.
// -----------------------------------------------------------------------------
module tb_btn_debounce;

    localparam int NB   = 2;
    localparam int DB   = 4;
    localparam int RD   = 10;
    localparam int RP   = 3;
    localparam int MAXC = 8192;

    logic          CLK_50M = 1'b0;
    logic          RST_N   = 1'b0;
    logic [NB-1:0] btn_in  = '0;

    logic [NB-1:0] lvl_a, press_a, rel_a;
    logic [NB-1:0] lvl_b, press_b, rel_b;

    always #5 CLK_50M = ~CLK_50M;

    btn_debounce #(
        .N_BTN           (NB),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .REPEAT_EN       (1'b1)
    ) u_dut_rep (
        .CLK_50M     (CLK_50M),
        .RST_N       (RST_N),
        .btn_in      (btn_in),
        .btn_level   (lvl_a),
        .btn_press   (press_a),
        .btn_release (rel_a)
    );

    btn_debounce #(
        .N_BTN           (NB),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .REPEAT_EN       (1'b0)
    ) u_dut_norep (
        .CLK_50M     (CLK_50M),
        .RST_N       (RST_N),
        .btn_in      (btn_in),
        .btn_level   (lvl_b),
        .btn_press   (press_b),
        .btn_release (rel_b)
    );

    typedef struct {
        int            cyc;
        logic [NB-1:0] pa, pb, ra, rb;
    } ev_t;

    ev_t           evq[$];
    int            cyc   = 0;
    int            tests = 0;
    int            fails = 0;
    bit            raw   [NB][MAXC];
    bit            lvl   [NB][MAXC];
    bit            rst_a [MAXC];
    int            rise_at [NB];
    logic [NB-1:0] exp_level = '0;
    int            p0_log[$];
    int            pb0_log[$];

    // Value seen at the second synchronizer stage during cycle j.
    function automatic bit sync_at(int ch, int j);
        if (j < 2) return 1'b0;
        if (rst_a[j] || rst_a[j-1]) return 1'b0;
        return raw[ch][j-2];
    endfunction

    // ---------------- reference model ----------------
    initial begin : model
        ev_t e;
        bit  prev, nxt, stable;
        int  held;
        rst_a[0] = 1'b1;
        forever begin
            @(posedge CLK_50M);
            if (cyc >= MAXC - 2) begin
                $display("FAIL model_budget cyc=%0d limit=%0d", cyc, MAXC - 2);
                $fatal(1, "model history exhausted");
            end
            cyc = cyc + 1;
            rst_a[cyc] = !RST_N;
            e.cyc = cyc; e.pa = '0; e.pb = '0; e.ra = '0; e.rb = '0;
            for (int ch = 0; ch < NB; ch++) begin
                raw[ch][cyc-1] = btn_in[ch];
                prev = lvl[ch][cyc-1];
                nxt  = prev;
                if (rst_a[cyc]) begin
                    nxt = 1'b0;
                end else if (cyc > DB) begin
                    // accept a change only if the last DB synchronized samples all disagree
                    stable = 1'b1;
                    for (int j = cyc - DB; j < cyc; j++) begin
                        if (sync_at(ch, j) == prev) stable = 1'b0;
                    end
                    if (stable) nxt = !prev;
                end
                lvl[ch][cyc] = nxt;
                if (!rst_a[cyc]) begin
                    if (nxt && !prev) begin
                        rise_at[ch] = cyc;
                        e.pa[ch] = 1'b1;
                        e.pb[ch] = 1'b1;
                    end else if (!nxt && prev) begin
                        e.ra[ch] = 1'b1;
                        e.rb[ch] = 1'b1;
                    end else if (nxt) begin
                        held = cyc - rise_at[ch];
                        if (held >= RD && ((held - RD) % RP) == 0) e.pa[ch] = 1'b1;
                    end
                end
                exp_level[ch] = nxt;
            end
            if (|{e.pa, e.pb, e.ra, e.rb}) evq.push_back(e);
        end
    end

    // Reset asserted mid-cycle wipes anything due in the current cycle.
    initial begin : model_reset
        forever begin
            @(negedge RST_N);
            while (evq.size() > 0 && evq[$].cyc >= cyc) void'(evq.pop_back());
            for (int ch = 0; ch < NB; ch++) lvl[ch][cyc] = 1'b0;
            exp_level = '0;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        ev_t e;
        forever begin
            @(negedge CLK_50M);
            if (!RST_N) begin
                tests++;
                if ({lvl_a, press_a, rel_a, lvl_b, press_b, rel_b} !== '0) begin
                    fails++;
                    $display("FAIL reset_outputs cyc=%0d got=%b want=0", cyc,
                             {lvl_a, press_a, rel_a, lvl_b, press_b, rel_b});
                end
            end else begin
                tests++;
                if (lvl_a !== exp_level || lvl_b !== exp_level) begin
                    fails++;
                    $display("FAIL level cyc=%0d got_rep=%b got_norep=%b want=%b", cyc,
                             lvl_a, lvl_b, exp_level);
                end
                while (evq.size() > 0 && evq[0].cyc < cyc) begin
                    tests++;
                    fails++;
                    $display("FAIL missed_event cyc=%0d got=none want pa=%b pb=%b ra=%b rb=%b",
                             evq[0].cyc, evq[0].pa, evq[0].pb, evq[0].ra, evq[0].rb);
                    void'(evq.pop_front());
                end
                if (|{press_a, press_b, rel_a, rel_b}) begin
                    tests++;
                    if (evq.size() == 0 || evq[0].cyc != cyc) begin
                        fails++;
                        $display("FAIL unexpected_pulse cyc=%0d got pa=%b pb=%b ra=%b rb=%b want=none",
                                 cyc, press_a, press_b, rel_a, rel_b);
                    end else begin
                        e = evq.pop_front();
                        if ({press_a, press_b, rel_a, rel_b} !== {e.pa, e.pb, e.ra, e.rb}) begin
                            fails++;
                            $display("FAIL pulse_vector cyc=%0d got=%b want=%b", cyc,
                                     {press_a, press_b, rel_a, rel_b}, {e.pa, e.pb, e.ra, e.rb});
                        end
                    end
                end
                if (press_a[0]) p0_log.push_back(cyc);
                if (press_b[0]) pb0_log.push_back(cyc);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK_50M);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic assert_reset();
        RST_N = 1'b0;
        #1;
        tests++;
        if ({lvl_a, press_a, rel_a, lvl_b, press_b, rel_b} !== '0) begin
            fails++;
            $display("FAIL async_reset cyc=%0d got=%b want=0", cyc,
                     {lvl_a, press_a, rel_a, lvl_b, press_b, rel_b});
        end
    endtask

    initial begin : stim
        int s;
        int got;
        int hold[NB];
        int exp_rep[7];
        exp_rep = '{6, 16, 19, 22, 25, 28, 31};

        idle(3);
        RST_N = 1'b1;
        idle(5);

        // Long hold on channel 0: press at +6 then repeats at +16, +19, ...
        p0_log.delete();
        pb0_log.delete();
        tick(); btn_in[0] = 1'b1; s = cyc;
        idle(29);
        tick(); btn_in[0] = 1'b0;
        idle(12);
        for (int i = 0; i < 7; i++) begin
            tests++;
            got = (i < p0_log.size()) ? p0_log[i] - s : -1;
            if (got != exp_rep[i]) begin
                fails++;
                $display("FAIL repeat_schedule idx=%0d got=%0d want=%0d", i, got, exp_rep[i]);
            end
        end
        tests++;
        if (pb0_log.size() != 1) begin
            fails++;
            $display("FAIL norepeat_count got=%0d want=1", pb0_log.size());
        end

        // Glitches of 1, 2, 3 cycles separated by 5 low cycles
        p0_log.delete();
        for (int w = 1; w <= 3; w++) begin
            tick(); btn_in[0] = 1'b1;
            idle(w - 1);
            tick(); btn_in[0] = 1'b0;
            idle(4);
        end
        idle(10);
        tests++;
        if (p0_log.size() != 0) begin
            fails++;
            $display("FAIL glitch_press got=%0d want=0", p0_log.size());
        end

        // Short press: one press, release, no repeat
        tick(); btn_in[0] = 1'b1;
        idle(7);
        tick(); btn_in[0] = 1'b0;
        idle(12);

        // Both channels together
        tick(); btn_in = 2'b11;
        idle(24);
        tick(); btn_in = 2'b00;
        idle(12);

        // Reset while repeating, button still held afterwards
        tick(); btn_in[0] = 1'b1;
        idle(21);
        tick(); assert_reset();
        idle(2);
        tick(); RST_N = 1'b1; s = cyc;
        p0_log.delete();
        idle(19);
        tick(); btn_in[0] = 1'b0;
        idle(12);
        tests++;
        got = (p0_log.size() > 0) ? p0_log[0] - s : -1;
        if (got != 6) begin
            fails++;
            $display("FAIL press_after_reset got=%0d want=6", got);
        end

        // Randomized holds, glitches and occasional resets
        for (int ch = 0; ch < NB; ch++) hold[ch] = $urandom_range(4, 40);
        for (int i = 0; i < 1500; i++) begin
            tick();
            for (int ch = 0; ch < NB; ch++) begin
                if (hold[ch] == 0) begin
                    btn_in[ch] = ~btn_in[ch];
                    hold[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                           : $urandom_range(4, 40);
                end else begin
                    hold[ch]--;
                end
            end
            if ($urandom_range(0, 399) == 0) begin
                assert_reset();
                idle($urandom_range(1, 3));
                tick(); RST_N = 1'b1;
            end
        end
        tick(); btn_in = '0;
        idle(60);

        tests++;
        if (evq.size() != 0) begin
            fails++;
            $display("FAIL leftover_events got=%0d want=0", evq.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
